// File: rtl/ysyx_23060201_lsu.sv
// ysyx_23060201_lsu: load/store unit between execute and the data-memory stage
module ysyx_23060201_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    input  logic [2:0]            in_funct3,
    input  logic                  in_is_load,
    input  logic                  in_is_store,
    input  logic [4:0]            in_rd,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [7:0]            mem_wmask,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic [4:0]            out_rd,
    output logic                  out_err
);
    typedef enum logic [1:0] {IDLE, STORE, LOAD_WAIT, RESP} state_t;
    state_t state, state_n;
    logic [1:0] off;
    logic [2:0] f3;
    logic [3:0] wmask_q, mask_in;
    logic [7:0] cnt;
    logic accept, misal, illegal, err_in, timeout;
    logic [DATA_WIDTH-1:0] shifted, ext;

    assign accept    = in_valid && in_ready;
    assign in_ready  = state == IDLE;
    assign mem_wen   = state == STORE;
    assign mem_ren   = state == LOAD_WAIT;
    assign out_valid = state == RESP;
    assign mem_wmask = {4'b0000, mem_wen ? wmask_q : 4'b0000};
    assign timeout   = cnt == 8'(RD_TIMEOUT - 1);

    always_comb begin
        misal   = (in_funct3[1:0] == 2'b01 && in_addr[0]) || (in_funct3[1:0] == 2'b10 && in_addr[1:0] != 2'b00);
        illegal = in_is_load ? (in_funct3 == 3'b011 || in_funct3[2:1] == 2'b11) : (in_funct3[2] || in_funct3[1:0] == 2'b11);
        err_in  = (in_is_load || in_is_store) && (misal || illegal);
        mask_in = in_funct3[1:0] == 2'b00 ? 4'b0001 << in_addr[1:0] :
                  in_funct3[1:0] == 2'b01 ? 4'b0011 << in_addr[1:0] : 4'b1111;
        shifted = mem_rdata >> {off, 3'b000};
        ext     = f3[1:0] == 2'b00 ? {{(DATA_WIDTH-8){~f3[2] & shifted[7]}}, shifted[7:0]} :
                  f3[1:0] == 2'b01 ? {{(DATA_WIDTH-16){~f3[2] & shifted[15]}}, shifted[15:0]} : shifted;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:      state_n = !accept ? IDLE : err_in ? RESP : in_is_load ? LOAD_WAIT : in_is_store ? STORE : RESP;
            STORE:     state_n = RESP;
            LOAD_WAIT: state_n = (mem_rvalid || timeout) ? RESP : LOAD_WAIT;
            RESP:      state_n = out_ready ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off       <= '0;
            f3        <= '0;
            wmask_q   <= '0;
            cnt       <= '0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            mem_raddr <= '0;
            out_rdata <= '0;
            out_rd    <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            off       <= in_addr[1:0];
            f3        <= in_funct3;
            wmask_q   <= mask_in;
            cnt       <= '0;
            mem_waddr <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_raddr <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata <= in_wdata << {in_addr[1:0], 3'b000};
            out_rdata <= '0;
            out_rd    <= in_rd;
            out_err   <= err_in;
        end else if (state == LOAD_WAIT) begin
            // response wins over a timeout landing on the same cycle
            if (mem_rvalid)   out_rdata <= ext;
            else if (timeout) out_err <= 1'b1;
            else              cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// tb_ysyx_23060201_lsu: directed vectors with hand-computed expectations
module tb_ysyx_23060201_lsu;
    logic clk = 0, rst_n = 0;
    logic in_valid = 0, in_ready, in_is_load = 0, in_is_store = 0;
    logic [31:0] in_addr = 0, in_wdata = 0;
    logic [2:0] in_funct3 = 0;
    logic [4:0] in_rd = 0, out_rd;
    logic mem_wen, mem_ren, mem_rvalid = 0, out_valid, out_ready = 0, out_err;
    logic [31:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata = 0, out_rdata;
    logic [7:0] mem_wmask;
    int cmp = 0, errs = 0;

    ysyx_23060201_lsu dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_funct3(in_funct3),
        .in_is_load(in_is_load), .in_is_store(in_is_store), .in_rd(in_rd),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_rd(out_rd), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] w, input logic [2:0] f,
                        input logic ld, input logic st, input logic [4:0] rd);
        @(negedge clk);
        check("in_ready", in_ready, 1);
        in_valid = 1; in_addr = a; in_wdata = w; in_funct3 = f;
        in_is_load = ld; in_is_store = st; in_rd = rd;
        @(negedge clk);
        in_valid = 0; in_is_load = 0; in_is_store = 0;
    endtask

    task automatic resp(input string tag, input logic [31:0] rdata, input logic err, input logic [4:0] rd);
        int n = 0;
        while (!out_valid && n < 400) begin @(negedge clk); n++; end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_rdata"}, out_rdata, rdata);
        check({tag, "_err"}, out_err, err);
        check({tag, "_rd"}, out_rd, rd);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        check({tag, "_drop"}, out_valid, 0);
        check({tag, "_idle"}, in_ready, 1);
    endtask

    task automatic store(input string tag, input logic [31:0] a, input logic [31:0] w, input logic [2:0] f,
                         input logic [31:0] ea, input logic [31:0] ew, input logic [7:0] em);
        send(a, w, f, 0, 1, 5'd7);
        check({tag, "_wen"}, mem_wen, 1);
        check({tag, "_waddr"}, mem_waddr, ea);
        check({tag, "_wdata"}, mem_wdata, ew);
        check({tag, "_wmask"}, mem_wmask, em);
        check({tag, "_ren"}, mem_ren, 0);
        @(negedge clk);
        check({tag, "_wen_off"}, mem_wen, 0);
        check({tag, "_mask_off"}, mem_wmask, 0);
        resp(tag, 0, 0, 5'd7);
    endtask

    task automatic load(input string tag, input logic [31:0] a, input logic [2:0] f, input int lat,
                        input logic [31:0] rdata, input logic [31:0] ea, input logic [31:0] exp);
        send(a, 0, f, 1, 0, 5'd12);
        for (int i = 0; i < lat; i++) begin
            check({tag, "_ren"}, mem_ren, 1);
            check({tag, "_raddr"}, mem_raddr, ea);
            if (i == lat - 1) begin mem_rvalid = 1; mem_rdata = rdata; end
            @(negedge clk);
        end
        mem_rvalid = 0; mem_rdata = 32'hFFFF_FFFF;
        check({tag, "_ren_off"}, mem_ren, 0);
        resp(tag, exp, 0, 5'd12);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_wen", mem_wen, 0);
        check("rst_ren", mem_ren, 0);
        check("rst_wmask", mem_wmask, 0);
        check("rst_waddr", mem_waddr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_err", out_err, 0);
        rst_n = 1;

        store("sb", 32'h8000_0003, 32'h0000_00AB, 3'b000, 32'h8000_0000, 32'hAB00_0000, 8'h08);
        store("sh", 32'h8000_0002, 32'h0000_1234, 3'b001, 32'h8000_0000, 32'h1234_0000, 8'h0C);
        store("sw", 32'h8000_0004, 32'hCAFE_F00D, 3'b010, 32'h8000_0004, 32'hCAFE_F00D, 8'h0F);

        load("lb", 32'h8000_0001, 3'b000, 3, 32'h0000_F000, 32'h8000_0000, 32'hFFFF_FFF0);
        load("lbu", 32'h8000_0001, 3'b100, 3, 32'h0000_F000, 32'h8000_0000, 32'h0000_00F0);
        load("lh", 32'h8000_0002, 3'b001, 2, 32'h8001_0000, 32'h8000_0000, 32'hFFFF_8001);
        load("lhu", 32'h8000_0006, 3'b101, 1, 32'h8001_0000, 32'h8000_0004, 32'h0000_8001);
        load("lw", 32'h8000_0008, 3'b010, 1, 32'hDEAD_BEEF, 32'h8000_0008, 32'hDEAD_BEEF);

        send(32'h8000_0002, 0, 3'b010, 1, 0, 5'd3);
        check("mis_ren", mem_ren, 0);
        check("mis_wen", mem_wen, 0);
        resp("mis", 0, 1, 5'd3);

        send(32'h8000_0001, 32'h55, 3'b001, 0, 1, 5'd4);
        check("mis_sh_wen", mem_wen, 0);
        resp("mis_sh", 0, 1, 5'd4);

        send(32'h8000_0000, 0, 3'b011, 1, 0, 5'd5);
        check("ill_ren", mem_ren, 0);
        resp("ill", 0, 1, 5'd5);

        send(32'h8000_0000, 32'h1111, 3'b000, 0, 0, 5'd6);
        resp("nop", 0, 0, 5'd6);

        send(32'h8000_0010, 0, 3'b010, 1, 0, 5'd9);
        n = 0;
        while (mem_ren && n < 400) begin n++; @(negedge clk); end
        check("to_cycles", n, 255);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", out_valid, 1);
            check("hold_err", out_err, 1);
            check("hold_rdata", out_rdata, 0);
            check("hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        mem_rvalid = 1;
        @(negedge clk);
        mem_rvalid = 0;
        resp("to", 0, 1, 5'd9);

        send(32'h8000_0020, 0, 3'b010, 1, 0, 5'd1);
        check("arst_ren_pre", mem_ren, 1);
        #2 rst_n = 0;
        #1 check("arst_ren", mem_ren, 0);
        check("arst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_wen", mem_wen, 0);
            check("arst_idle", in_ready, 1);
            check("arst_valid", out_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
